spi_state_loader: RTL
=====================

# spi_state_loader

SPI master that loads 32-bit state-control words into the state handler's configuration FIFO over its serial control port (`ctr_clk`, `ctr_cs`, `dataIn`, `ctr_enable`). It accepts words from the host side through a valid/ready handshake and shifts each word out MSB first. A word is latched at the far end when chip-select rises. The block holds `ctr_enable` low for a whole load session and releases it after the word flagged last, which restarts the state machine on the freshly loaded FIFO.

## Interface
Parameters:
- `WIDTH`, 32, bits per word; receiver shift-register width.
- `HALF`, 1, `mainclk` cycles per SCLK half-period (≥1).
- `GAP`, 2, `mainclk` cycles that `spi_cs` is held high after each word (≥1).

Ports:
- `mainclk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `wordIn`  in  WIDTH  word to send.
- `wordValid`  in  1  `wordIn`/`wordLast` are valid.
- `wordLast`  in  1  final word of the session.
- `wordReady`  out  1  block can accept a word.
- `busy`  out  1  a word is being shifted or is in its CS gap.
- `wordsSent`  out  8  words completed in the current session (wraps at 256).
- `spi_sclk`  out  1  serial clock, idle low.
- `spi_mosi`  out  1  serial data.
- `spi_cs`  out  1  chip-select, active low.
- `ctr_enable`  out  1  state-machine enable; low while loading.

## Operation
- Reset values (registered, one edge after `reset` is high):
  - `spi_cs`=1, `spi_sclk`=0, `spi_mosi`=0, `ctr_enable`=1.
  - `busy`=0, `wordReady`=0, `wordsSent`=0, state IDLE.
- Handshake:
  - `wordReady`=1 in IDLE from the first cycle after `reset` deasserts.
  - A transfer is accepted on an edge with `wordValid && wordReady`; `wordIn` and `wordLast` are captured on that edge.
  - `wordReady` is 0 from the next cycle until the transfer returns to IDLE. `wordValid` while not ready is ignored.
- States: IDLE → SHIFT_LO → SHIFT_HI → (next bit SHIFT_LO | TRAIL) → GAP → IDLE.
  - SHIFT_LO: `spi_sclk`=0 and `spi_mosi`=current bit, for HALF cycles.
  - SHIFT_HI: `spi_sclk`=1 for HALF cycles; MOSI is stable. The receiver samples on the SCLK rising edge.
  - TRAIL: `spi_sclk`=0 and `spi_cs` still low, for HALF cycles.
  - GAP: `spi_cs`=1 for GAP cycles.
- Bit order: `wordIn[WIDTH-1]` first, `wordIn[0]` last. Exactly WIDTH rising SCLK edges per word.
- Session:
  - The first accepted word after IDLE with `ctr_enable`=1 drives `ctr_enable` low and clears `wordsSent` to 0.
  - `wordsSent` increments on the last GAP cycle.
  - If the word had `wordLast`=1, `ctr_enable` returns to 1 in the same cycle the state returns to IDLE. Otherwise `ctr_enable` stays low in IDLE, awaiting further words.
- Reset mid-word: the word is aborted and all outputs take their reset values on the next edge. The receiver sees CS rise with a partial word, which is not a valid latch; the host must reload.

## Timing
- Accept edge T:
  - At T+1: `spi_cs`=0, `ctr_enable`=0, `spi_mosi`=MSB, `busy`=1.
  - First SCLK rise at T+1+HALF.
- `spi_cs` low duration: WIDTH·2·HALF + HALF cycles; 65 cycles at the defaults.
- Word period, accept edge to next possible accept edge: WIDTH·2·HALF + HALF + GAP + 1 cycles; 68 cycles at the defaults.
- MOSI changes only while `spi_sclk`=0: at least HALF cycles of setup and HALF cycles of hold around every rising edge.
- Back-to-back: `wordValid` held high gives the next accept on the first IDLE cycle, so CS is high for exactly GAP+1 cycles between words.

## Structure
- Package `spi_loader_pkg`:
  - state enum.
  - default constants `WIDTH_DEF`=32, `HALF_DEF`=1, `GAP_DEF`=2.
  - state-control field offsets shared with the state handler: sampling[1:0], transmitter bit 2, frequency[4:3], trigger bit 5, output interface[7:6], measure bit 8, retransmit bit 9, state duration[19:16].
- Sub-module `shift_out_register` (parallel load, shift-MSB-out on an enable strobe): the transmit counterpart of the receiver shift-in register.
- The FSM, half-period counter, bit counter and session logic live in the top.

## Test plan
- Reset: hold `reset` for 3 cycles → all outputs at their reset values. `wordReady`=1 on the first cycle after release.
- Single word `32'hA5000001` with `wordLast`=1, defaults:
  - 32 SCLK rises; MOSI sampled at the rises = 1010_0101_0…0_0001.
  - `spi_cs` low for 65 cycles.
  - `ctr_enable` rises with the return to IDLE; `wordsSent`=1.
- Four-word session `32'h0003_0207`, `32'h0007_020B`, `32'h000B_0213`, `32'h000E_0023`, last on the 4th:
  - The receiving state-handler model latches all 4 in order.
  - `ctr_enable` stays low throughout and rises only after the 4th GAP; `wordsSent`=4.
- Back-to-back: `wordValid` held high → consecutive accepts exactly 68 cycles apart. `wordValid` while busy causes no extra accept.
- Reset at the 10th SCLK rise of a word → next edge `spi_cs`=1, `spi_sclk`=0, `ctr_enable`=1, `wordsSent`=0. A new word then sends cleanly.
- `HALF`=2, `GAP`=3 → SCLK period 4 cycles, CS low 130 cycles, CS high between back-to-back words 4 cycles.

Source files
------------

// File: rtl/spi_loader_pkg.sv
// Shared definitions for the SPI state-control loader: default geometry,
// FSM state encodings and the state-control word layout used by the state handler.
package spi_loader_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned HALF_DEF  = 1;
  localparam int unsigned GAP_DEF   = 2;

  localparam int unsigned STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SHIFT_LO = 3'd1;
  localparam logic [2:0] ST_SHIFT_HI = 3'd2;
  localparam logic [2:0] ST_TRAIL    = 3'd3;
  localparam logic [2:0] ST_GAP      = 3'd4;

  // Field offsets inside a state-control word, shared with the state handler.
  localparam int unsigned SAMPLING_LSB    = 0;
  localparam int unsigned SAMPLING_W      = 2;
  localparam int unsigned TRANSMITTER_BIT = 2;
  localparam int unsigned FREQUENCY_LSB   = 3;
  localparam int unsigned FREQUENCY_W     = 2;
  localparam int unsigned TRIGGER_BIT     = 5;
  localparam int unsigned OUT_IF_LSB      = 6;
  localparam int unsigned OUT_IF_W        = 2;
  localparam int unsigned MEASURE_BIT     = 8;
  localparam int unsigned RETRANSMIT_BIT  = 9;
  localparam int unsigned DURATION_LSB    = 16;
  localparam int unsigned DURATION_W      = 4;

  typedef struct packed {
    logic [11:0] rsvd_hi;
    logic [3:0]  duration;
    logic [5:0]  rsvd_mid;
    logic        retransmit;
    logic        measure;
    logic [1:0]  out_if;
    logic        trigger;
    logic [1:0]  frequency;
    logic        transmitter;
    logic [1:0]  sampling;
  } state_ctrl_t;

  // Assemble a state-control word from its individual fields.
  function automatic logic [31:0] make_ctrl_word(
    input logic [3:0] duration,
    input logic       retransmit,
    input logic       measure,
    input logic [1:0] out_if,
    input logic       trigger,
    input logic [1:0] frequency,
    input logic       transmitter,
    input logic [1:0] sampling
  );
    state_ctrl_t c;
    c             = '0;
    c.duration    = duration;
    c.retransmit  = retransmit;
    c.measure     = measure;
    c.out_if      = out_if;
    c.trigger     = trigger;
    c.frequency   = frequency;
    c.transmitter = transmitter;
    c.sampling    = sampling;
    return c;
  endfunction

endpackage

// File: rtl/spi_state_loader_shift.sv
// Parallel-load, MSB-first shift-out register; transmit counterpart of the
// state handler's shift-in register. Zeros are shifted in behind the data.
module shift_out_register
  import spi_loader_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             shift_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;

  always_comb begin
    sreg_d = sreg_q;
    if (load_i) begin
      sreg_d = data_i;
    end else if (shift_i) begin
      sreg_d = sreg_q << 1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign msb_o = sreg_q[WIDTH-1];

endmodule

// File: rtl/spi_state_loader.sv
// SPI master loading state-control words into the state handler's config FIFO;
// holds ctr_enable low for a load session and releases it after the last word.
module spi_state_loader
  import spi_loader_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned HALF  = HALF_DEF,
  parameter int unsigned GAP   = GAP_DEF
) (
  input  logic             mainclk,
  input  logic             reset,
  input  logic [WIDTH-1:0] wordIn,
  input  logic             wordValid,
  input  logic             wordLast,
  output logic             wordReady,
  output logic             busy,
  output logic [7:0]       wordsSent,
  output logic             spi_sclk,
  output logic             spi_mosi,
  output logic             spi_cs,
  output logic             ctr_enable
);

  localparam int unsigned CNT_MAX = (HALF > GAP) ? HALF : GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             last_q, last_d;
  logic [7:0]       sent_q, sent_d;
  logic             cen_q, cen_d;
  logic             sclk_q, sclk_d;
  logic             cs_q, cs_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  logic             accept_c;
  logic             load_c;
  logic             shift_c;
  logic             mosi_c;

  assign accept_c = wordValid && ready_q && (state_q == ST_IDLE);

  // Next-state, counters and session bookkeeping; outputs decode the next state
  // so every pin is a flop that changes together with the state.
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    bit_d   = bit_q;
    last_d  = last_q;
    sent_d  = sent_q;
    cen_d   = cen_q;
    load_c  = 1'b0;
    shift_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = ST_SHIFT_LO;
          half_d  = '0;
          bit_d   = '0;
          last_d  = wordLast;
          load_c  = 1'b1;
          cen_d   = 1'b0;
          if (cen_q) begin
            sent_d = '0;
          end
        end
      end
      ST_SHIFT_LO: begin
        if (half_q == HALF_LAST) begin
          state_d = ST_SHIFT_HI;
          half_d  = '0;
        end else begin
          half_d = half_q + CNT_W'(1);
        end
      end
      ST_SHIFT_HI: begin
        if (half_q == HALF_LAST) begin
          half_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = ST_TRAIL;
          end else begin
            state_d = ST_SHIFT_LO;
            bit_d   = bit_q + BIT_W'(1);
            shift_c = 1'b1;
          end
        end else begin
          half_d = half_q + CNT_W'(1);
        end
      end
      ST_TRAIL: begin
        if (half_q == HALF_LAST) begin
          state_d = ST_GAP;
          half_d  = '0;
        end else begin
          half_d = half_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (half_q == GAP_LAST) begin
          state_d = ST_IDLE;
          half_d  = '0;
          sent_d  = sent_q + 8'd1;
          if (last_q) begin
            cen_d = 1'b1;
          end
        end else begin
          half_d = half_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        half_d  = '0;
        bit_d   = '0;
      end
    endcase

    sclk_d  = (state_d == ST_SHIFT_HI);
    cs_d    = !((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI) ||
                (state_d == ST_TRAIL));
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge mainclk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      half_q  <= '0;
      bit_q   <= '0;
      last_q  <= 1'b0;
      sent_q  <= '0;
      cen_q   <= 1'b1;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
      sent_q  <= sent_d;
      cen_q   <= cen_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  // MOSI comes straight from the shift register MSB, which only moves as SCLK falls.
  shift_out_register #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk_i   (mainclk),
    .rst_i   (reset),
    .load_i  (load_c),
    .data_i  (wordIn),
    .shift_i (shift_c),
    .msb_o   (mosi_c)
  );

  assign wordReady  = ready_q;
  assign busy       = busy_q;
  assign wordsSent  = sent_q;
  assign spi_sclk   = sclk_q;
  assign spi_mosi   = mosi_c;
  assign spi_cs     = cs_q;
  assign ctr_enable = cen_q;

endmodule
